// File: rtl/reg_pkg.sv
// Shared types and widths for the register-file writeback path.
package reg_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding MDU writeback requests until a free slot opens.
module wb_fifo
  import reg_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  wb_req_t din_i,
  input  logic    pop_i,
  output wb_req_t dout_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push_s;
  logic          do_pop_s;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o   = (wptr_q == rptr_q);
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign dout_o    = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push_s) begin
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Merges MEM/WB and buffered MDU results onto the register-file write port,
// tracking MDU-pending registers and requesting a stall when MDU results starve.
module reg_wb_arbiter
  import reg_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_wr_en,
  input  logic [REG_ADDR_W-1:0] pipe_wr_addr,
  input  logic [DATA_W-1:0]     pipe_wr_data,
  input  logic                  mdu_issue,
  input  logic [REG_ADDR_W-1:0] mdu_issue_addr,
  input  logic                  mdu_res_valid,
  input  logic [REG_ADDR_W-1:0] mdu_res_addr,
  input  logic [DATA_W-1:0]     mdu_res_data,
  output logic                  mdu_res_ready,
  output logic                  r3_wr,
  output logic [REG_ADDR_W-1:0] r3_addr,
  output logic [DATA_W-1:0]     r3_din,
  output logic [31:0]           busy,
  output logic                  stall_req,
  output logic                  waw_err
);

  localparam int CW = $clog2(STARVE_MAX) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);

  wb_req_t               head_s;
  wb_req_t               res_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  pipe_live_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  waw_hit_s;

  logic                  r3_wr_q,   r3_wr_d;
  logic [REG_ADDR_W-1:0] r3_addr_q, r3_addr_d;
  logic [DATA_W-1:0]     r3_din_q,  r3_din_d;
  logic [31:0]           busy_q,    busy_d;
  logic                  stall_q,   stall_d;
  logic                  waw_q,     waw_d;
  logic [CW-1:0]         cnt_q,     cnt_d;

  assign res_s.addr    = mdu_res_addr;
  assign res_s.data    = mdu_res_data;
  assign mdu_res_ready = !full_s;
  assign pipe_live_s   = pipe_wr_en && (pipe_wr_addr != REG_ZERO);
  assign push_s        = mdu_res_valid && !full_s;
  assign pop_s         = !pipe_live_s && !empty_s;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .din_i   (res_s),
    .pop_i   (pop_s),
    .dout_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Write-port selection, scoreboard, protocol check and starvation tracking.
  always_comb begin
    r3_wr_d   = 1'b0;
    r3_addr_d = r3_addr_q;
    r3_din_d  = r3_din_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    stall_d   = stall_q;

    if (pipe_live_s) begin
      r3_wr_d   = 1'b1;
      r3_addr_d = pipe_wr_addr;
      r3_din_d  = pipe_wr_data;
    end else if (pop_s && (head_s.addr != REG_ZERO)) begin
      r3_wr_d   = 1'b1;
      r3_addr_d = head_s.addr;
      r3_din_d  = head_s.data;
    end else begin
      r3_wr_d   = 1'b0;
    end

    // Clear before set so an issue to the register being retired keeps it busy.
    if (pop_s && (head_s.addr != REG_ZERO)) begin
      busy_d[head_s.addr] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (mdu_issue && (mdu_issue_addr != REG_ZERO)) begin
      busy_d[mdu_issue_addr] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;

    waw_hit_s = (pipe_live_s && busy_q[pipe_wr_addr])
              || (mdu_issue && (mdu_issue_addr != REG_ZERO) && busy_q[mdu_issue_addr]
                  && !(pop_s && (head_s.addr == mdu_issue_addr)))
              || (mdu_res_valid && !busy_q[mdu_res_addr]);
    waw_d = waw_q || waw_hit_s;

    if (empty_s || pop_s) begin
      cnt_d   = '0;
      stall_d = 1'b0;
    end else if (pipe_live_s) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = cnt_q;
        stall_d = 1'b1;
      end else begin
        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        stall_d = stall_q;
      end
    end else begin
      cnt_d   = cnt_q;
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r3_wr_q   <= 1'b0;
      r3_addr_q <= '0;
      r3_din_q  <= '0;
      busy_q    <= '0;
      stall_q   <= 1'b0;
      waw_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      r3_wr_q   <= r3_wr_d;
      r3_addr_q <= r3_addr_d;
      r3_din_q  <= r3_din_d;
      busy_q    <= busy_d;
      stall_q   <= stall_d;
      waw_q     <= waw_d;
      cnt_q     <= cnt_d;
    end
  end

  assign r3_wr     = r3_wr_q;
  assign r3_addr   = r3_addr_q;
  assign r3_din    = r3_din_q;
  assign busy      = busy_q;
  assign stall_req = stall_q;
  assign waw_err   = waw_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomized and directed bench for reg_wb_arbiter against a queue-based reference model.
module tb_reg_wb_arbiter;

  localparam int DEPTH  = 2;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_wr_en;
  logic [4:0]  pipe_wr_addr;
  logic [31:0] pipe_wr_data;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_addr;
  logic        mdu_res_valid;
  logic [4:0]  mdu_res_addr;
  logic [31:0] mdu_res_data;
  logic        mdu_res_ready;
  logic        r3_wr;
  logic [4:0]  r3_addr;
  logic [31:0] r3_din;
  logic [31:0] busy;
  logic        stall_req;
  logic        waw_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit [36:0]   m_q[$];
  bit [31:0]   m_busy;
  bit          m_wr;
  bit [4:0]    m_addr;
  bit [31:0]   m_din;
  bit          m_stall;
  bit          m_waw;
  int          m_blk;
  bit [4:0]    pend[$];
  bit          acc;

  reg_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_wr_en     (pipe_wr_en),
    .pipe_wr_addr   (pipe_wr_addr),
    .pipe_wr_data   (pipe_wr_data),
    .mdu_issue      (mdu_issue),
    .mdu_issue_addr (mdu_issue_addr),
    .mdu_res_valid  (mdu_res_valid),
    .mdu_res_addr   (mdu_res_addr),
    .mdu_res_data   (mdu_res_data),
    .mdu_res_ready  (mdu_res_ready),
    .r3_wr          (r3_wr),
    .r3_addr        (r3_addr),
    .r3_din         (r3_din),
    .busy           (busy),
    .stall_req      (stall_req),
    .waw_err        (waw_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = '0; m_wr = 1'b0; m_addr = '0; m_din = '0;
    m_stall = 1'b0; m_waw = 1'b0; m_blk = 0;
    pend.delete();
  endtask

  task automatic idle_inputs();
    pipe_wr_en = 1'b0; pipe_wr_addr = '0; pipe_wr_data = '0;
    mdu_issue = 1'b0; mdu_issue_addr = '0;
    mdu_res_valid = 1'b0; mdu_res_addr = '0; mdu_res_data = '0;
  endtask

  // One clock: predict from the model, clock the DUT, compare everything.
  task automatic step(output bit accepted);
    bit live, push, pop, was_nonempty;
    bit [4:0] ha;
    bit [31:0] hd;
    ha = '0; hd = '0;
    live = pipe_wr_en && (pipe_wr_addr != 5'd0);
    check_eq("ready", {31'd0, mdu_res_ready}, {31'd0, (m_q.size() < DEPTH)});
    push = mdu_res_valid && (m_q.size() < DEPTH);
    pop  = !live && (m_q.size() != 0);
    was_nonempty = (m_q.size() != 0);
    if (pop) {ha, hd} = m_q[0];
    accepted = push && rst_n;

    if (!rst_n) begin
      m_q.delete();
      m_busy = '0; m_wr = 1'b0; m_addr = '0; m_din = '0;
      m_stall = 1'b0; m_waw = 1'b0; m_blk = 0;
    end else begin
      if (live && m_busy[pipe_wr_addr]) m_waw = 1'b1;
      if (mdu_issue && mdu_issue_addr != 5'd0 && m_busy[mdu_issue_addr]
          && !(pop && ha == mdu_issue_addr)) m_waw = 1'b1;
      if (mdu_res_valid && !m_busy[mdu_res_addr]) m_waw = 1'b1;

      if (live) begin
        m_wr = 1'b1; m_addr = pipe_wr_addr; m_din = pipe_wr_data;
      end else if (pop && ha != 5'd0) begin
        m_wr = 1'b1; m_addr = ha; m_din = hd;
      end else begin
        m_wr = 1'b0;
      end

      if (pop && ha != 5'd0) m_busy[ha] = 1'b0;
      if (mdu_issue && mdu_issue_addr != 5'd0) m_busy[mdu_issue_addr] = 1'b1;

      if (was_nonempty && live) begin
        if (m_blk >= STARVE - 1) m_stall = 1'b1;
        m_blk++;
      end else begin
        m_blk = 0;
        m_stall = 1'b0;
      end

      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({mdu_res_addr, mdu_res_data});
    end

    @(posedge clk);
    #1;
    check_eq("r3_wr",   {31'd0, r3_wr}, {31'd0, m_wr});
    check_eq("r3_addr", {27'd0, r3_addr}, {27'd0, m_addr});
    check_eq("r3_din",  r3_din, m_din);
    check_eq("busy",    busy, m_busy);
    check_eq("stall",   {31'd0, stall_req}, {31'd0, m_stall});
    check_eq("waw",     {31'd0, waw_err}, {31'd0, m_waw});
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(acc);
    rst_n = 1'b1;
    pend.delete();
  endtask

  initial begin
    bit [4:0] r;
    int guard;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_eq("rst_r3_wr", {31'd0, r3_wr}, 32'd0);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_ready", {31'd0, mdu_res_ready}, 32'd1);
    rst_n = 1'b1;

    // T1: pipe write latency, then addr-0 write ignored
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd5; pipe_wr_data = 32'h1234;
    step(acc);
    check_eq("t1_wr", {31'd0, r3_wr}, 32'd1);
    check_eq("t1_addr", {27'd0, r3_addr}, 32'd5);
    check_eq("t1_din", r3_din, 32'h1234);
    pipe_wr_addr = 5'd0; pipe_wr_data = 32'h5555;
    step(acc);
    check_eq("t1_zero_wr", {31'd0, r3_wr}, 32'd0);
    idle_inputs();

    // T2: issue 8, result 3 cycles later, write 2 cycles after accept
    mdu_issue = 1'b1; mdu_issue_addr = 5'd8;
    step(acc);
    idle_inputs();
    step(acc); step(acc);
    mdu_res_valid = 1'b1; mdu_res_addr = 5'd8; mdu_res_data = 32'hDEADBEEF;
    step(acc);
    check_eq("t2_acc", {31'd0, acc}, 32'd1);
    check_eq("t2_busy_hold", {31'd0, busy[8]}, 32'd1);
    idle_inputs();
    step(acc);
    check_eq("t2_wr", {31'd0, r3_wr}, 32'd1);
    check_eq("t2_addr", {27'd0, r3_addr}, 32'd8);
    check_eq("t2_din", r3_din, 32'hDEADBEEF);
    check_eq("t2_busy_clr", {31'd0, busy[8]}, 32'd0);

    // T3: FIFO fills under a busy pipe, stall, ordered drain
    for (int i = 9; i <= 11; i++) begin
      mdu_issue = 1'b1; mdu_issue_addr = 5'(i);
      step(acc);
    end
    idle_inputs();
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd20;
    for (int i = 9; i <= 11; i++) begin
      mdu_res_valid = 1'b1; mdu_res_addr = 5'(i); mdu_res_data = 32'hA000_0000 + 32'(i);
      pipe_wr_data = $urandom;
      if (i == 11) check_eq("t3_ready_full", {31'd0, mdu_res_ready}, 32'd0);
      step(acc);
    end
    guard = 0;
    while (!stall_req && guard < 10) begin
      pipe_wr_data = $urandom;
      step(acc);
      guard++;
    end
    check_eq("t3_stall", {31'd0, stall_req}, 32'd1);
    check_eq("t3_blocked_cycles", 32'(guard), 32'd2);
    pipe_wr_en = 1'b0;
    for (int i = 9; i <= 11; i++) begin
      step(acc);
      if (acc) mdu_res_valid = 1'b0;
      check_eq("t3_order", {27'd0, r3_addr}, 32'(i));
      check_eq("t3_drain_wr", {31'd0, r3_wr}, 32'd1);
      if (i == 9) check_eq("t3_stall_drop", {31'd0, stall_req}, 32'd0);
    end
    idle_inputs();

    // T4: retire and reissue reg 12 in one cycle
    mdu_issue = 1'b1; mdu_issue_addr = 5'd12;
    step(acc);
    idle_inputs();
    mdu_res_valid = 1'b1; mdu_res_addr = 5'd12; mdu_res_data = 32'h0C0C;
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd3; pipe_wr_data = 32'h3;
    step(acc);
    idle_inputs();
    mdu_issue = 1'b1; mdu_issue_addr = 5'd12;
    step(acc);
    check_eq("t4_busy12", {31'd0, busy[12]}, 32'd1);
    check_eq("t4_waw", {31'd0, waw_err}, 32'd0);

    // T5: pipe write to a busy register sets the sticky flag
    idle_inputs();
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd12; pipe_wr_data = 32'h77;
    step(acc);
    check_eq("t5_waw", {31'd0, waw_err}, 32'd1);
    check_eq("t5_wr_addr", {27'd0, r3_addr}, 32'd12);
    idle_inputs();
    repeat (3) step(acc);
    check_eq("t5_sticky", {31'd0, waw_err}, 32'd1);

    // T6: reset with two results buffered
    do_reset();
    mdu_issue = 1'b1; mdu_issue_addr = 5'd8; step(acc);
    mdu_issue_addr = 5'd9; step(acc);
    idle_inputs();
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd3;
    mdu_res_valid = 1'b1; mdu_res_addr = 5'd8; mdu_res_data = 32'h8; step(acc);
    mdu_res_addr = 5'd9; mdu_res_data = 32'h9; step(acc);
    check_eq("t6_busy", busy, 32'h300);
    check_eq("t6_full", {31'd0, mdu_res_ready}, 32'd0);
    do_reset();
    check_eq("t6_busy_rst", busy, 32'd0);
    check_eq("t6_wr_rst", {31'd0, r3_wr}, 32'd0);
    check_eq("t6_ready_rst", {31'd0, mdu_res_ready}, 32'd1);
    check_eq("t6_waw_rst", {31'd0, waw_err}, 32'd0);

    // Randomized traffic respecting the MDU and stall protocol
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      if (!mdu_res_valid && pend.size() != 0 && $urandom_range(0, 9) < 4) begin
        int k;
        k = $urandom_range(0, pend.size() - 1);
        mdu_res_valid = 1'b1; mdu_res_addr = pend[k]; mdu_res_data = $urandom;
        pend.delete(k);
      end
      mdu_issue = 1'b0;
      if ($urandom_range(0, 9) < 3) begin
        for (int t = 0; t < 4; t++) begin
          r = 5'($urandom_range(1, 31));
          if (!m_busy[r] && !(mdu_res_valid && mdu_res_addr == r)) begin
            mdu_issue = 1'b1; mdu_issue_addr = r;
            break;
          end
        end
      end
      pipe_wr_en = 1'b0;
      if (!m_stall && $urandom_range(0, 9) < 6) begin
        r = 5'($urandom_range(0, 31));
        if (m_busy[r]) r = 5'($urandom_range(0, 31));
        pipe_wr_en = 1'b1; pipe_wr_addr = r; pipe_wr_data = $urandom;
      end
      step(acc);
      if (mdu_issue) pend.push_back(mdu_issue_addr);
      if (acc) mdu_res_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
